// File: rtl/demux_rr_dispatcher.sv
// ============================================================================
// Module      : demux_rr_dispatcher
// Description : Dispatches a valid/ready word stream to one of N_CH channels,
//               round-robin or addressed per word, with an optional stall timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_rr_dispatcher #(
  parameter int DW     = 8,
  parameter int N_CH   = 8,
  parameter int SEL_W  = 3,
  parameter int TO_CYC = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [SEL_W-1:0] in_dest,
  input  logic             in_mode,
  output logic [N_CH-1:0]  out_valid,
  input  logic [N_CH-1:0]  out_ready,
  output logic [DW-1:0]    out_data,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             err_drop
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  localparam int               c_TO_W    = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam int               c_TO_LAST = (TO_CYC > 0) ? TO_CYC - 1 : 0;
  localparam logic [SEL_W-1:0] c_LAST_CH = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   c_N_CH    = (SEL_W + 1)'(N_CH);

  state_t            r_state;
  logic [DW-1:0]     r_data;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  r_rr_ptr;
  logic              r_mode;
  logic              r_err_drop;
  logic [c_TO_W-1:0] r_to_cnt;

  logic              w_full;
  logic [N_CH-1:0]   w_valid;
  logic              w_hs;
  logic              w_timeout;
  logic [SEL_W-1:0]  w_sel_next;
  logic [SEL_W-1:0]  w_rr_ptr_nxt;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_bad;
  logic              w_load;

  assign w_full = (r_state == S_FULL);

  for (genvar i = 0; i < N_CH; i++) begin : g_valid
    assign w_valid[i] = w_full && (r_sel == SEL_W'(i));
  end

  assign w_hs       = |(w_valid & out_ready);
  assign w_timeout  = (TO_CYC > 0) && w_full && !w_hs &&
                      (r_to_cnt == c_TO_W'(c_TO_LAST));
  assign w_sel_next = (r_sel == c_LAST_CH) ? '0 : r_sel + 1'b1;

  // The RR pointer advances when an RR word leaves or is retargeted; a word
  // loaded in the same cycle already sees the advanced pointer.
  assign w_rr_ptr_nxt = ((w_hs || w_timeout) && !r_mode) ? w_sel_next : r_rr_ptr;

  assign w_in_ready = !w_full || (w_hs && !w_timeout);
  assign w_accept   = in_valid && w_in_ready;
  assign w_bad      = w_accept && in_mode && ({1'b0, in_dest} >= c_N_CH);
  assign w_load     = w_accept && !w_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_data     <= '0;
      r_sel      <= '0;
      r_rr_ptr   <= '0;
      r_mode     <= 1'b0;
      r_err_drop <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_err_drop <= w_bad || (w_timeout && r_mode);
      r_rr_ptr   <= w_rr_ptr_nxt;
      if (w_load) begin
        r_state  <= S_FULL;
        r_data   <= in_data;
        r_mode   <= in_mode;
        r_sel    <= in_mode ? in_dest : w_rr_ptr_nxt;
        r_to_cnt <= '0;
      end else if (w_hs) begin
        r_state  <= S_EMPTY;
        r_to_cnt <= '0;
      end else if (w_timeout) begin
        r_to_cnt <= '0;
        if (r_mode) begin
          r_state <= S_EMPTY;
        end else begin
          r_sel <= w_sel_next;
        end
      end else if (w_full && (TO_CYC > 0)) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_valid;
  assign out_data  = r_data;
  assign sel       = r_sel;
  assign busy      = w_full;
  assign err_drop  = r_err_drop;

endmodule

`default_nettype wire

// File: tb/tb_demux_rr_dispatcher.sv
// ============================================================================
// Module      : tb_demux_rr_dispatcher
// Description : Scoreboard bench for demux_rr_dispatcher in three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_rr_dispatcher;

  typedef struct packed {
    logic       drop;
    logic [2:0] ch;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  // dut a: defaults, no timeout
  logic       a_in_valid = 0, a_in_ready, a_in_mode = 0, a_busy, a_err_drop;
  logic [7:0] a_in_data = 0, a_out_data, a_out_valid, a_out_ready = 0;
  logic [2:0] a_in_dest = 0, a_sel;
  // dut b: TO_CYC = 4
  logic       b_in_valid = 0, b_in_ready, b_in_mode = 0, b_busy, b_err_drop;
  logic [7:0] b_in_data = 0, b_out_data, b_out_valid, b_out_ready = 0;
  logic [2:0] b_in_dest = 0, b_sel;
  // dut c: N_CH = 6
  logic       c_in_valid = 0, c_in_ready, c_in_mode = 0, c_busy, c_err_drop;
  logic [7:0] c_in_data = 0, c_out_data;
  logic [5:0] c_out_valid, c_out_ready = 0;
  logic [2:0] c_in_dest = 0, c_sel;

  demux_rr_dispatcher #(.DW(8), .N_CH(8), .SEL_W(3), .TO_CYC(0)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_dest(a_in_dest), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .sel(a_sel), .busy(a_busy), .err_drop(a_err_drop));

  demux_rr_dispatcher #(.DW(8), .N_CH(8), .SEL_W(3), .TO_CYC(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_dest(b_in_dest), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .sel(b_sel), .busy(b_busy), .err_drop(b_err_drop));

  demux_rr_dispatcher #(.DW(8), .N_CH(6), .SEL_W(3), .TO_CYC(0)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_dest(c_in_dest), .in_mode(c_in_mode),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .sel(c_sel), .busy(c_busy), .err_drop(c_err_drop));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic d, input logic [2:0] ch, input logic [7:0] data);
    exp_t e;
    e.drop = d;
    e.ch   = ch;
    e.data = data;
    return e;
  endfunction

  // Monitors: every output transfer or drop pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (a_err_drop) begin
        if (qa.size() == 0) chk("a_unexpected_drop", 1, 0);
        else begin e = qa.pop_front(); chk("a_drop_kind", e.drop, 1); end
      end
      if (|(a_out_valid & a_out_ready)) begin
        if (qa.size() == 0) chk("a_unexpected_xfer", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_xfer_kind", e.drop, 0);
          chk("a_xfer_sel", a_sel, e.ch);
          chk("a_xfer_valid", a_out_valid, 32'd1 << e.ch);
          chk("a_xfer_data", a_out_data, e.data);
        end
      end
      if (b_err_drop) begin
        if (qb.size() == 0) chk("b_unexpected_drop", 1, 0);
        else begin e = qb.pop_front(); chk("b_drop_kind", e.drop, 1); end
      end
      if (|(b_out_valid & b_out_ready)) begin
        if (qb.size() == 0) chk("b_unexpected_xfer", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_xfer_kind", e.drop, 0);
          chk("b_xfer_sel", b_sel, e.ch);
          chk("b_xfer_valid", b_out_valid, 32'd1 << e.ch);
          chk("b_xfer_data", b_out_data, e.data);
        end
      end
      if (c_err_drop) begin
        if (qc.size() == 0) chk("c_unexpected_drop", 1, 0);
        else begin e = qc.pop_front(); chk("c_drop_kind", e.drop, 1); end
      end
      if (|(c_out_valid & c_out_ready)) begin
        if (qc.size() == 0) chk("c_unexpected_xfer", 1, 0);
        else begin
          e = qc.pop_front();
          chk("c_xfer_kind", e.drop, 0);
          chk("c_xfer_sel", c_sel, e.ch);
          chk("c_xfer_valid", c_out_valid, 32'd1 << e.ch);
          chk("c_xfer_data", c_out_data, e.data);
        end
      end
    end
  end

  task automatic a_word(input logic m, input logic [2:0] d, input logic [7:0] v);
    a_in_valid = 1; a_in_mode = m; a_in_dest = d; a_in_data = v;
    @(negedge clk); chk("a_in_ready_accept", a_in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic b_word(input logic m, input logic [2:0] d, input logic [7:0] v);
    b_in_valid = 1; b_in_mode = m; b_in_dest = d; b_in_data = v;
    @(negedge clk); chk("b_in_ready_accept", b_in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic c_word(input logic m, input logic [2:0] d, input logic [7:0] v);
    c_in_valid = 1; c_in_mode = m; c_in_dest = d; c_in_data = v;
    @(negedge clk); chk("c_in_ready_accept", c_in_ready, 1);
    @(posedge clk); #1;
  endtask

  logic [2:0] rr8_ch[10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
  logic [2:0] rr6_ch[7]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_sel", a_sel, 0);
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_a_err_drop", a_err_drop, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    chk("rst_c_busy", c_busy, 0);
    @(posedge clk); #1;

    // Held word on ch2 is discarded by reset
    a_out_ready = 8'h00;
    a_word(1, 3'd2, 8'h22);
    a_in_valid = 0;
    @(negedge clk);
    chk("t1_full_valid", a_out_valid, 8'h04);
    chk("t1_full_sel", a_sel, 2);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("t1_rst_out_valid", a_out_valid, 0);
    chk("t1_rst_busy", a_busy, 0);
    chk("t1_rst_sel", a_sel, 0);
    chk("t1_rst_in_ready", a_in_ready, 1);
    @(posedge clk); #1 rst = 0;

    // Back-to-back RR words walk through all channels
    a_out_ready = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      qa.push_back(mk(0, rr8_ch[i], 8'h10 + 8'(i)));
      a_word(0, 3'd0, 8'h10 + 8'(i));
    end
    a_in_valid = 0;

    // Addressed word to ch5; RR pointer (now 2) must stay put
    qa.push_back(mk(0, 3'd5, 8'hA5));
    a_word(1, 3'd5, 8'hA5);
    a_in_valid = 0;
    @(negedge clk);
    chk("t3_out_valid", a_out_valid, 8'h20);
    chk("t3_out_data", a_out_data, 8'hA5);
    chk("t3_sel", a_sel, 5);
    @(posedge clk); #1;

    // RR word on ch2 stalls 5 cycles with no timeout; follower goes to ch3
    a_out_ready = 8'hFB;
    qa.push_back(mk(0, 3'd2, 8'h44));
    qa.push_back(mk(0, 3'd3, 8'h45));
    a_in_valid = 1; a_in_mode = 0; a_in_data = 8'h44;
    @(posedge clk); #1;
    a_in_data = 8'h45;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_stall_in_ready", a_in_ready, 0);
      chk("t4_stall_data", a_out_data, 8'h44);
      chk("t4_stall_sel", a_sel, 2);
      @(posedge clk); #1;
    end
    a_out_ready = 8'hFF;
    @(negedge clk);
    chk("t4_release_in_ready", a_in_ready, 1);
    @(posedge clk); #1 a_in_valid = 0;
    @(negedge clk);
    chk("t4_next_sel", a_sel, 3);
    chk("t4_next_valid", a_out_valid, 8'h08);
    @(posedge clk); #1;

    // Timeout: RR word on ch7 retargets to ch0 after 4 cycles
    b_out_ready = 8'hFF;
    for (int i = 0; i < 7; i++) begin
      qb.push_back(mk(0, 3'(i), 8'hB0 + 8'(i)));
      b_word(0, 3'd0, 8'hB0 + 8'(i));
    end
    b_out_ready = 8'h7F;
    qb.push_back(mk(0, 3'd0, 8'hB7));
    b_word(0, 3'd0, 8'hB7);
    b_in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_rr_hold_valid", b_out_valid, 8'h80);
      chk("t5_rr_hold_in_ready", b_in_ready, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t5_rr_retarget_sel", b_sel, 0);
    chk("t5_rr_retarget_valid", b_out_valid, 8'h01);
    @(posedge clk); #1;

    // Timeout: addressed word to ch3 dropped after 4 cycles
    b_out_ready = 8'hF7;
    qb.push_back(mk(1, 3'd0, 8'h00));
    b_word(1, 3'd3, 8'hB3);
    b_in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_ad_hold_valid", b_out_valid, 8'h08);
      chk("t5_ad_hold_err", b_err_drop, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t5_ad_err_drop", b_err_drop, 1);
    chk("t5_ad_busy", b_busy, 0);
    chk("t5_ad_out_valid", b_out_valid, 0);
    @(posedge clk); #1;
    // RR pointer is 1 after the ch0 transfer; the drop must not move it
    b_out_ready = 8'hFF;
    qb.push_back(mk(0, 3'd1, 8'hBB));
    b_word(0, 3'd0, 8'hBB);
    b_in_valid = 0;

    // N_CH = 6: dest 6 and 7 are out of range
    c_out_ready = 6'h3F;
    qc.push_back(mk(1, 3'd0, 8'h00));
    c_word(1, 3'd6, 8'hC6);
    qc.push_back(mk(1, 3'd0, 8'h00));
    c_word(1, 3'd7, 8'hC7);
    c_in_valid = 0;
    @(negedge clk);
    chk("t6_err_drop", c_err_drop, 1);
    chk("t6_out_valid", c_out_valid, 0);
    chk("t6_busy", c_busy, 0);
    @(posedge clk); #1;
    qc.push_back(mk(0, 3'd5, 8'hC5));
    c_word(1, 3'd5, 8'hC5);
    c_in_valid = 0;
    @(negedge clk);
    chk("t6_last_ch_valid", c_out_valid, 6'h20);
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      qc.push_back(mk(0, rr6_ch[i], 8'hD0 + 8'(i)));
      c_word(0, 3'd0, 8'hD0 + 8'(i));
    end
    c_in_valid = 0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("qc_drained", qc.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
